pooled_frame_serializer: RTL and testbench
==========================================

Name: pooled_frame_serializer

Overview:
- Reader at the output end of the average-pooling stage: captures one flat pooled frame (default 14x14, 8-bit pixels) and streams it one pixel per beat over a valid/ready interface.
- Output stream goes to the downstream classifier input.
- Frame capture is triggered by a single-cycle start pulse.
- Provides a row/column position and a last-pixel flag with each beat.

Parameters:
- resolution, 8, bits per pixel.
- matrix_side_length, 14, frame side; N = matrix_side_length**2 pixels per frame.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 resets the block.
- start  input  1  capture input_pixels and begin streaming; sampled only in IDLE.
- input_pixels  input  resolution*N  flat frame. Pixel k occupies bits [k*resolution +: resolution]; k = row*matrix_side_length + col.
- busy  output  1  high in STREAM and DONE.
- out_pixel  output  resolution  current pixel.
- out_valid  output  1  beat available.
- out_ready  input  1  downstream accepts the beat.
- out_row  output  $clog2(matrix_side_length)  row of current pixel.
- out_col  output  $clog2(matrix_side_length)  column of current pixel.
- out_last  output  1  current beat is pixel N-1.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - Frame register, pixel index, out_row and out_col cleared to 0.
  - busy, out_valid, out_last, done and out_pixel are 0.
- States: IDLE, STREAM, DONE.
- IDLE:
  - start=1 at edge k latches input_pixels into an internal frame register.
  - Index, row and col are set to 0; state moves to STREAM.
  - out_valid=1 from cycle k+1, so first-beat latency is 1 cycle.
  - Changes on input_pixels after capture have no effect.
- STREAM:
  - out_valid=1.
  - out_pixel = frame[index]; out_row and out_col track index.
  - out_last = (index == N-1).
- Transfer rule: a beat transfers on an edge with out_valid & out_ready.
  - While out_ready=0, out_pixel, out_row, out_col and out_last are held stable.
- On transfer with index < N-1:
  - Index increments.
  - col increments; at col == matrix_side_length-1, col wraps to 0 and row increments.
  - Row and col come from counters, not division.
- On transfer with out_last=1:
  - State moves to DONE; out_valid=0 next cycle.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy=0 in the same cycle done falls.
- start while busy: ignored with no restart. A start in the DONE cycle is also ignored.
- start and the final transfer in the same cycle: start is ignored.
- Index counter is $clog2(N) bits. The frame register is resolution*N bits, with pixels indexed by the counter.
- Mid-operation reset: streaming aborts immediately, with no done pulse. The next start begins a fresh frame at pixel 0.

Optional Feature:
- Macro: FRAME_SUM_EN.
- When defined:
  - Adds output frame_sum, width resolution+$clog2(N) (16 at defaults).
  - Cleared on reset and on frame capture.
  - Adds out_pixel on every accepted beat.
  - Holds its value from the done pulse until the next capture.
- When undefined: the port and accumulator are absent, and the rest of the behaviour is unchanged.

Test Plan:
- Ramp frame, out_ready tied 1:
  - Stimulus: pixel k = k; pulse start.
  - First beat (0, row 0, col 0) one cycle after start.
  - 196 consecutive beats; beat 195 = 195 with row 13, col 13, out_last=1.
  - done pulse on the following cycle.
- Backpressure:
  - Stimulus: same frame; out_ready low for 3 cycles during beat 14.
  - out_pixel=14, row 1, col 0 held all 3 cycles.
  - No beat lost or duplicated; still 196 beats.
- Start while busy:
  - Stimulus: second start with an all-0xFF frame at beat 50 and again in the DONE cycle.
  - Stream continues with ramp values; exactly one done pulse.
- Reset mid-stream:
  - Stimulus: reset=0 at beat 100.
  - out_valid=0 and busy=0 asynchronously; no done pulse.
  - Then start with all-3 frame: beats restart at index 0 with value 3.
- Input change after capture:
  - Stimulus: overwrite input_pixels with zeros one cycle after start.
  - Streamed values remain the captured ramp.
- FRAME_SUM_EN:
  - All-3 frame: frame_sum = 588 at done.
  - Ramp frame: frame_sum = 19110 at done.

Source files
------------

// File: rtl/pooled_frame_serializer.sv
// ============================================================================
// pooled_frame_serializer
// ----------------------------------------------------------------------------
// Captures one flat pooled frame (matrix_side_length x matrix_side_length
// pixels, resolution bits each) on a start pulse and streams it out one
// pixel per beat over a valid/ready handshake, tagging each beat with its
// row/column position and a last-pixel flag. A one-cycle done pulse follows
// acceptance of the final beat.
//
// Optional feature (compile-time macro FRAME_SUM_EN):
//   adds output frame_sum, the running sum of all accepted pixels of the
//   current frame, cleared on reset and on capture, held after done.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   start         in   capture input_pixels and begin streaming (IDLE only)
//   input_pixels  in   flat frame, pixel k at [k*resolution +: resolution],
//                      k = row*matrix_side_length + col
//   busy          out  high while streaming and during the done cycle
//   out_pixel     out  current pixel (0 when no beat is offered)
//   out_valid     out  beat available
//   out_ready     in   downstream accepts the beat
//   out_row       out  row of the current pixel
//   out_col       out  column of the current pixel
//   out_last      out  current beat is the final pixel of the frame
//   done          out  one-cycle pulse after the last beat is accepted
//   frame_sum     out  (FRAME_SUM_EN only) sum of accepted pixels
// ============================================================================
module pooled_frame_serializer #(
    parameter int resolution         = 8,
    parameter int matrix_side_length = 14
) (
    input  logic                                                       clk,
    input  logic                                                       reset,
    input  logic                                                       start,
    input  logic [resolution*matrix_side_length*matrix_side_length-1:0] input_pixels,
    output logic                                                       busy,
    output logic [resolution-1:0]                                      out_pixel,
    output logic                                                       out_valid,
    input  logic                                                       out_ready,
    output logic [$clog2(matrix_side_length)-1:0]                      out_row,
    output logic [$clog2(matrix_side_length)-1:0]                      out_col,
    output logic                                                       out_last,
    output logic                                                       done
`ifdef FRAME_SUM_EN
    ,
    output logic [resolution+$clog2(matrix_side_length*matrix_side_length)-1:0] frame_sum
`endif
);

    localparam int N     = matrix_side_length * matrix_side_length;
    localparam int IDX_W = $clog2(N);
    localparam int RC_W  = $clog2(matrix_side_length);
`ifdef FRAME_SUM_EN
    localparam int SUM_W = resolution + IDX_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [resolution-1:0]   frame_q [N];
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [RC_W-1:0]         row_q;
    logic [RC_W-1:0]         row_d;
    logic [RC_W-1:0]         col_q;
    logic [RC_W-1:0]         col_d;
    logic                    valid_q;
    logic                    busy_q;
    logic                    last_q;
    logic                    last_d;
    logic                    done_q;
    logic                    idx_is_last;
`ifdef FRAME_SUM_EN
    logic [SUM_W-1:0]        sum_q;
`endif

    // Position of the next beat. Row/column advance with a wrapping column
    // counter so no divider is needed to derive them from the flat index.
    always_comb begin
        idx_d       = idx_q + IDX_W'(1);
        idx_is_last = (idx_q == IDX_W'(N - 1));
        last_d      = (idx_d == IDX_W'(N - 1));
        if (col_q == RC_W'(matrix_side_length - 1)) begin
            col_d = '0;
            row_d = row_q + RC_W'(1);
        end else begin
            col_d = col_q + RC_W'(1);
            row_d = row_q;
        end
    end

    // Control FSM. All handshake outputs are registered so they change only
    // at clock edges and stay stable while the downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            for (int k = 0; k < N; k++) begin
                frame_q[k] <= '0;
            end
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FRAME_SUM_EN
            sum_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < N; k++) begin
                            frame_q[k] <= input_pixels[k*resolution +: resolution];
                        end
                        idx_q   <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= (N == 1);
`ifdef FRAME_SUM_EN
                        sum_q   <= '0;
`endif
                        state_q <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (out_ready) begin
`ifdef FRAME_SUM_EN
                        sum_q <= sum_q + SUM_W'(frame_q[idx_q]);
`endif
                        if (idx_is_last) begin
                            // Final beat accepted: drop valid, pulse done.
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q  <= idx_d;
                            row_q  <= row_d;
                            col_q  <= col_d;
                            last_q <= last_d;
                        end
                    end
                end

                S_DONE: begin
                    // start is deliberately not sampled here.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    last_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel mux is gated so the bus reads 0 whenever no beat is offered.
    assign out_pixel = valid_q ? frame_q[idx_q] : '0;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;
    assign done      = done_q;
`ifdef FRAME_SUM_EN
    assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_pooled_frame_serializer.sv
module tb_pooled_frame_serializer;

    localparam int RES  = 8;
    localparam int SIDE = 14;
    localparam int N    = SIDE * SIDE;
    localparam int RW   = $clog2(SIDE);
    localparam int MAXC = 3000;

    logic               clk;
    logic               reset;
    logic               start;
    logic [RES*N-1:0]   input_pixels;
    logic               busy;
    logic [RES-1:0]     out_pixel;
    logic               out_valid;
    logic               out_ready;
    logic [RW-1:0]      out_row;
    logic [RW-1:0]      out_col;
    logic               out_last;
    logic               done;
`ifdef FRAME_SUM_EN
    logic [RES+$clog2(N)-1:0] frame_sum;
`endif

    pooled_frame_serializer #(
        .resolution         (RES),
        .matrix_side_length (SIDE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .input_pixels (input_pixels),
        .busy         (busy),
        .out_pixel    (out_pixel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .done         (done)
`ifdef FRAME_SUM_EN
        ,
        .frame_sum    (frame_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the frame the bench intends the DUT to stream.
    int model[N];
    int model_sum;

    // Observations gathered by the collector.
    logic [RES-1:0] obs_pix[$];
    logic [RW-1:0]  obs_row[$];
    logic [RW-1:0]  obs_col[$];
    logic           obs_last[$];
    logic [RES-1:0] st_pix[$];
    logic [RW-1:0]  st_row[$];
    logic [RW-1:0]  st_col[$];
    logic           st_last[$];
    int  beats, done_cnt, first_valid_cyc, last_cyc, done_cyc, valid_after_done;
    bit  timed_out, aborted;
    logic post_valid, post_busy;
    int  sum_at_done;

    // kind 0: ramp k, 1: constant val, 2: random
    task automatic set_frame(input int kind, input int val);
        model_sum = 0;
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       model[k] = k % 256;
                1:       model[k] = val;
                default: model[k] = $urandom_range(0, 255);
            endcase
            input_pixels[k*RES +: RES] = RES'(model[k]);
            model_sum += model[k];
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
    endtask

    // Drives out_ready / extra stimulus and records what the DUT offers.
    task automatic collect(input int rdy_mode, input int stall_beat, input int start_beat,
                           input bit start_in_done, input int abort_beat, input bit zero_after);
        int cyc, after, stall_cnt, sb;
        bit stalled;
        obs_pix.delete(); obs_row.delete(); obs_col.delete(); obs_last.delete();
        st_pix.delete(); st_row.delete(); st_col.delete(); st_last.delete();
        beats = 0; done_cnt = 0; first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
        valid_after_done = 0; timed_out = 0; aborted = 0; sum_at_done = -1;
        after = -1; stall_cnt = 0; stalled = 0; sb = start_beat;
        for (cyc = 0; cyc < MAXC; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (zero_after && cyc == 0) input_pixels = '0;
            if (after >= 0 && out_valid) valid_after_done++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
`ifdef FRAME_SUM_EN
                sum_at_done = int'(frame_sum);
`endif
                if (start_in_done) begin
                    input_pixels = '1;
                    start = 1'b1;
                end
                if (after < 0) after = 0;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && beats == abort_beat) begin
                reset = 1'b0;
                #1;
                post_valid = out_valid;
                post_busy  = busy;
                aborted    = 1;
                out_ready  = 1'b0;
                break;
            end
            if (out_valid && beats == sb) begin
                input_pixels = '1;
                start = 1'b1;
                sb = -1;
            end
            if (out_valid && beats == stall_beat && !stalled) begin
                stalled = 1;
                stall_cnt = 3;
            end
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
                st_pix.push_back(out_pixel); st_row.push_back(out_row);
                st_col.push_back(out_col);   st_last.push_back(out_last);
            end else begin
                out_ready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (out_valid && out_ready) begin
                obs_pix.push_back(out_pixel); obs_row.push_back(out_row);
                obs_col.push_back(out_col);   obs_last.push_back(out_last);
                if (out_last) last_cyc = cyc;
                beats++;
            end
            if (after >= 0) begin
                after++;
                if (after > 4) break;
            end
        end
        if (cyc >= MAXC) timed_out = 1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; out_ready = 1'b0; input_pixels = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_done_last: got %b/%b expected 0/0", done, out_last); end
        n_cmp++; if (out_pixel !== '0 || out_row !== '0 || out_col !== '0) begin
            n_fail++; $display("FAIL reset_pos: got pix %0d row %0d col %0d expected 0", out_pixel, out_row, out_col); end
`ifdef FRAME_SUM_EN
        n_cmp++; if (frame_sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %0d expected 0", frame_sum); end
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        set_frame(0, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_idle_valid: got %b expected 0", out_valid); end
        pulse_start();
        collect(0, -1, -1, 0, -1, 0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL ramp_timeout: got timeout expected completion"); end
        n_cmp++; if (first_valid_cyc !== 0) begin n_fail++; $display("FAIL ramp_latency: got %0d expected 0", first_valid_cyc); end
        n_cmp++; if (beats !== N) begin n_fail++; $display("FAIL ramp_beats: got %0d expected %0d", beats, N); end
        for (int k = 0; k < obs_pix.size() && k < N; k++) begin
            n_cmp++;
            if (obs_pix[k] !== RES'(model[k]) || obs_row[k] !== RW'(k / SIDE) ||
                obs_col[k] !== RW'(k % SIDE) || obs_last[k] !== (k == N - 1)) begin
                n_fail++;
                $display("FAIL ramp_beat%0d: got pix %0d r%0d c%0d l%b expected pix %0d r%0d c%0d l%b",
                         k, obs_pix[k], obs_row[k], obs_col[k], obs_last[k], model[k], k / SIDE, k % SIDE, k == N - 1);
            end
        end
        n_cmp++; if (last_cyc !== N - 1) begin n_fail++; $display("FAIL ramp_last_cycle: got %0d expected %0d", last_cyc, N - 1); end
        n_cmp++; if (done_cyc !== N || done_cnt !== 1) begin
            n_fail++; $display("FAIL ramp_done: got cycle %0d count %0d expected cycle %0d count 1", done_cyc, done_cnt, N); end
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_idle_after: got busy %b valid %b expected 0/0", busy, out_valid); end
`ifdef FRAME_SUM_EN
        n_cmp++; if (sum_at_done !== model_sum) begin n_fail++; $display("FAIL ramp_sum: got %0d expected %0d", sum_at_done, model_sum); end
        n_cmp++; if (int'(frame_sum) !== model_sum) begin n_fail++; $display("FAIL ramp_sum_hold: got %0d expected %0d", frame_sum, model_sum); end
`endif
    endtask

    task automatic test_backpressure();
        set_frame(0, 0);
        pulse_start();
        collect(0, 14, -1, 0, -1, 0);
        n_cmp++; if (st_pix.size() !== 3) begin n_fail++; $display("FAIL bp_stall_len: got %0d expected 3", st_pix.size()); end
        for (int i = 0; i < st_pix.size(); i++) begin
            n_cmp++;
            if (st_pix[i] !== 8'd14 || st_row[i] !== RW'(1) || st_col[i] !== RW'(0) || st_last[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got pix %0d r%0d c%0d l%b expected pix 14 r1 c0 l0",
                         i, st_pix[i], st_row[i], st_col[i], st_last[i]);
            end
        end
        n_cmp++; if (beats !== N || timed_out) begin n_fail++; $display("FAIL bp_beats: got %0d expected %0d", beats, N); end
        for (int k = 0; k < obs_pix.size() && k < N; k++) begin
            n_cmp++;
            if (obs_pix[k] !== RES'(model[k]) || obs_row[k] !== RW'(k / SIDE) || obs_col[k] !== RW'(k % SIDE)) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got pix %0d r%0d c%0d expected pix %0d r%0d c%0d",
                         k, obs_pix[k], obs_row[k], obs_col[k], model[k], k / SIDE, k % SIDE);
            end
        end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        set_frame(0, 0);
        pulse_start();
        collect(0, -1, 50, 1, -1, 0);
        n_cmp++; if (beats !== N || timed_out) begin n_fail++; $display("FAIL swb_beats: got %0d expected %0d", beats, N); end
        for (int k = 0; k < obs_pix.size() && k < N; k++) begin
            n_cmp++;
            if (obs_pix[k] !== RES'(model[k])) begin
                n_fail++; $display("FAIL swb_beat%0d: got %0d expected %0d", k, obs_pix[k], model[k]);
            end
        end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL swb_done: got %0d expected 1", done_cnt); end
        n_cmp++; if (valid_after_done !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL swb_restart: got valid cycles %0d busy %b expected 0/0", valid_after_done, busy); end
    endtask

    task automatic test_reset_mid();
        int dcount;
        set_frame(0, 0);
        pulse_start();
        collect(0, -1, -1, 0, 100, 0);
        n_cmp++; if (!aborted || beats !== 100) begin n_fail++; $display("FAIL rst_reach: got beats %0d expected 100", beats); end
        n_cmp++; if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got valid %b busy %b expected 0/0", post_valid, post_busy); end
        dcount = done_cnt;
        repeat (2) begin @(negedge clk); if (done === 1'b1) dcount++; end
        reset = 1'b1;
        repeat (3) begin @(negedge clk); if (done === 1'b1 || out_valid === 1'b1) dcount++; end
        n_cmp++; if (dcount !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d expected 0", dcount); end
        set_frame(1, 3);
        pulse_start();
        collect(1, -1, -1, 0, -1, 0);
        n_cmp++; if (beats !== N || timed_out) begin n_fail++; $display("FAIL rst_restart_beats: got %0d expected %0d", beats, N); end
        for (int k = 0; k < obs_pix.size() && k < N; k++) begin
            n_cmp++;
            if (obs_pix[k] !== 8'd3 || obs_row[k] !== RW'(k / SIDE) || obs_col[k] !== RW'(k % SIDE)) begin
                n_fail++;
                $display("FAIL rst_beat%0d: got pix %0d r%0d c%0d expected pix 3 r%0d c%0d",
                         k, obs_pix[k], obs_row[k], obs_col[k], k / SIDE, k % SIDE);
            end
        end
`ifdef FRAME_SUM_EN
        n_cmp++; if (sum_at_done !== 588) begin n_fail++; $display("FAIL rst_sum: got %0d expected 588", sum_at_done); end
`endif
    endtask

    task automatic test_input_change();
        set_frame(0, 0);
        pulse_start();
        collect(0, -1, -1, 0, -1, 1);
        n_cmp++; if (beats !== N || timed_out) begin n_fail++; $display("FAIL inchg_beats: got %0d expected %0d", beats, N); end
        for (int k = 0; k < obs_pix.size() && k < N; k++) begin
            n_cmp++;
            if (obs_pix[k] !== RES'(model[k])) begin
                n_fail++; $display("FAIL inchg_beat%0d: got %0d expected %0d", k, obs_pix[k], model[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 2; f++) begin
            set_frame(2, 0);
            pulse_start();
            collect(1, -1, -1, 0, -1, 0);
            n_cmp++; if (beats !== N || timed_out) begin n_fail++; $display("FAIL rnd%0d_beats: got %0d expected %0d", f, beats, N); end
            for (int k = 0; k < obs_pix.size() && k < N; k++) begin
                n_cmp++;
                if (obs_pix[k] !== RES'(model[k]) || obs_row[k] !== RW'(k / SIDE) ||
                    obs_col[k] !== RW'(k % SIDE) || obs_last[k] !== (k == N - 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_beat%0d: got pix %0d r%0d c%0d l%b expected pix %0d r%0d c%0d l%b",
                             f, k, obs_pix[k], obs_row[k], obs_col[k], obs_last[k], model[k], k / SIDE, k % SIDE, k == N - 1);
                end
            end
            n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rnd%0d_done: got %0d expected 1", f, done_cnt); end
`ifdef FRAME_SUM_EN
            n_cmp++; if (sum_at_done !== model_sum) begin n_fail++; $display("FAIL rnd%0d_sum: got %0d expected %0d", f, sum_at_done, model_sum); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_input_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
